// File: rtl/fsm_stim_pkg.sv
// Shared types and constants for the FSM stimulus serializer.
package fsm_stim_pkg;

  // Serializer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } stim_state_t;

  // Width of the inter-word idle counter (GAP is 0..255)
  localparam int unsigned GAP_CNT_W = 8;

endpackage

// File: rtl/fsm_stim_holdreg.sv
// One-entry holding buffer: captures a word on a valid/ready handshake and
// releases it when the serializer pulls it into the shift register.
module fsm_stim_holdreg
  import fsm_stim_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load,
  output logic [WIDTH-1:0] buf_data,
  output logic             buf_full
);

  // A full buffer blocks upstream, so capture and load never coincide
  assign in_ready = ~buf_full;

  // Buffer contents and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (in_valid && in_ready) begin
      buf_data <= in_data;
      buf_full <= 1'b1;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

endmodule

// File: rtl/fsm_stim_serializer.sv
// Parallel-to-serial stimulus stage driving the single-bit x input of the
// sequence FSMs; gapless for back-to-back words, optional idle gap per word.
module fsm_stim_serializer
  import fsm_stim_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP        = 0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned          CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
  localparam bit                   HAS_GAP  = (GAP != 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  stim_state_t          state;
  stim_state_t          state_nxt;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     shreg_shifted_c;
  logic [CNT_W-1:0]     bitcnt;
  logic [GAP_CNT_W-1:0] gapcnt;
  logic [WIDTH-1:0]     buf_data;
  logic                 buf_full;
  logic                 load_c;
  logic                 last_bit_c;

  fsm_stim_holdreg #(
    .WIDTH (WIDTH)
  ) u_holdreg (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load     (load_c),
    .buf_data (buf_data),
    .buf_full (buf_full)
  );

  assign last_bit_c = (state == ST_SHIFT) && (bitcnt == LAST_BIT);

  // Move the shift register one place toward the output end
  assign shreg_shifted_c = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and buffer-load strobe
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (buf_full) begin
          load_c    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bitcnt == LAST_BIT) begin
          if (HAS_GAP) begin
            state_nxt = ST_GAP;
          end else if (buf_full) begin
            load_c    = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gapcnt == '0) begin
          if (buf_full) begin
            load_c    = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, bit counter and gap counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
    end else begin
      if (load_c) begin
        shreg  <= buf_data;
        bitcnt <= '0;
      end else if (state == ST_SHIFT) begin
        shreg  <= shreg_shifted_c;
        bitcnt <= bitcnt + CNT_W'(1);
      end

      if (HAS_GAP && last_bit_c) begin
        gapcnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gapcnt != '0)) begin
        gapcnt <= gapcnt - GAP_CNT_W'(1);
      end
    end
  end

  // Serial outputs decoded from registered state only
  always_comb begin
    x         = IDLE_LEVEL;
    x_valid   = 1'b0;
    word_done = 1'b0;
    if (state == ST_SHIFT) begin
      x         = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      x_valid   = 1'b1;
      word_done = last_bit_c;
    end
  end

  assign busy = (state != ST_IDLE) || buf_full;

endmodule

// File: tb/tb_fsm_stim_serializer.sv
// Self-checking bench: two serializer configurations checked every cycle
// against a timeline model (accept edge / start edge arithmetic).
module tb_fsm_stim_serializer;

  localparam int W     = 8;
  localparam int N     = 2;
  localparam int GAP_A = 0;
  localparam int GAP_B = 2;
  localparam bit MSB_A = 1'b1;
  localparam bit MSB_B = 1'b0;
  localparam bit IDL_A = 1'b0;
  localparam bit IDL_B = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_data  [N];
  logic         in_valid [N];
  logic         in_ready [N];
  logic         x        [N];
  logic         x_valid  [N];
  logic         word_done[N];
  logic         busy     [N];

  fsm_stim_serializer #(.WIDTH(W), .MSB_FIRST(MSB_A), .GAP(GAP_A), .IDLE_LEVEL(IDL_A)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x(x[0]), .x_valid(x_valid[0]),
    .word_done(word_done[0]), .busy(busy[0]));

  fsm_stim_serializer #(.WIDTH(W), .MSB_FIRST(MSB_B), .GAP(GAP_B), .IDLE_LEVEL(IDL_B)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x(x[1]), .x_valid(x_valid[1]),
    .word_done(word_done[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each accepted word has accept edge a and load edge s
  typedef struct {
    int           d;
    logic [W-1:0] data;
    longint       a;
    longint       s;
  } acc_t;

  acc_t         mq[$];
  longint       last_s[N];
  longint       cyc = 0;
  bit           took[N];
  bit           cap0[$];
  bit           cap1[$];
  longint       vc0[$];
  longint       vc1[$];
  logic [W-1:0] accq0[$];

  function automatic int gap_of(input int d);
    return (d == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic bit msb_of(input int d);
    return (d == 0) ? MSB_A : MSB_B;
  endfunction

  function automatic bit idle_of(input int d);
    return (d == 0) ? IDL_A : IDL_B;
  endfunction

  // Buffer is occupied from the accept edge up to the load edge
  function automatic bit exp_ready(input int d, input longint c);
    foreach (mq[k]) if (mq[k].d == d && mq[k].a <= c && c < mq[k].s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_busy(input int d, input longint c);
    foreach (mq[k])
      if (mq[k].d == d && mq[k].a <= c && c < mq[k].s + W + gap_of(d)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void exp_bit(input int d, input longint c,
                                  output bit v, output bit b, output bit done);
    v = 1'b0; b = idle_of(d); done = 1'b0;
    foreach (mq[k]) begin
      if (mq[k].d == d && mq[k].s <= c && c < mq[k].s + W) begin
        int idx;
        idx  = int'(c - mq[k].s);
        v    = 1'b1;
        b    = msb_of(d) ? mq[k].data[W-1-idx] : mq[k].data[idx];
        done = (idx == W - 1);
      end
    end
  endfunction

  task automatic chk(input string name, input int d, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", name, d, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int d, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d exp=%0d", name, d, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int d);
    n_checks++;
    n_fail++;
    $display("FAIL %s dut%0d timeout at cyc=%0d", name, d, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle monitor: compare every output, then record handshakes
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      for (int d = 0; d < N; d++) last_s[d] = -1000;
    end
    for (int k = mq.size() - 1; k >= 0; k--)
      if (mq[k].s + W + gap_of(mq[k].d) + 2 < cyc) mq.delete(k);
    for (int d = 0; d < N; d++) begin
      bit ev, eb, ed;
      exp_bit(d, cyc, ev, eb, ed);
      chk("x_valid",   d, x_valid[d],   ev);
      chk("x",         d, x[d],         eb);
      chk("word_done", d, word_done[d], ed);
      chk("in_ready",  d, in_ready[d],  exp_ready(d, cyc));
      chk("busy",      d, busy[d],      exp_busy(d, cyc));
      if (x_valid[d]) begin
        if (d == 0) begin cap0.push_back(x[d]); vc0.push_back(cyc); end
        else        begin cap1.push_back(x[d]); vc1.push_back(cyc); end
      end
      if (reset && in_valid[d] && exp_ready(d, cyc)) begin
        acc_t e;
        longint earliest;
        e.d = d; e.data = in_data[d]; e.a = cyc + 1;
        earliest = last_s[d] + W + gap_of(d);
        e.s = (e.a + 1 > earliest) ? e.a + 1 : earliest;
        last_s[d] = e.s;
        mq.push_back(e);
        took[d] = 1'b1;
        if (d == 0) accq0.push_back(in_data[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_took(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (took[d]) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("handshake", d);
    took[d] = 1'b0;
  endtask

  task automatic send(input int d, input logic [W-1:0] v);
    took[d]     = 1'b0;
    in_data[d]  = v;
    in_valid[d] = 1'b1;
    wait_took(d);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!exp_busy(d, cyc)) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("idle", d);
    tick();
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); vc0.delete(); vc1.delete(); accq0.delete();
  endtask

  function automatic logic [15:0] pack_cap(input int d);
    logic [15:0] r;
    r = '0;
    if (d == 0) foreach (cap0[i]) r = {r[14:0], cap0[i]};
    else        foreach (cap1[i]) r = {r[14:0], cap1[i]};
    return r;
  endfunction

  typedef struct {
    int           d;
    logic [W-1:0] data;
    logic [W-1:0] seq;   // bits in emission order, first bit in MSB
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0, 8'hA5, 8'b1010_0101};
    tbl[1] = '{0, 8'h3C, 8'b0011_1100};
    tbl[2] = '{1, 8'h01, 8'b1000_0000};
    tbl[3] = '{1, 8'h80, 8'b0000_0001};
    tbl[4] = '{1, 8'hC8, 8'b0001_0011};

    for (int d = 0; d < N; d++) begin
      in_data[d] = '0; in_valid[d] = 1'b0; took[d] = 1'b0; last_s[d] = -1000;
    end

    // Reset state
    repeat (3) tick();
    for (int d = 0; d < N; d++) begin
      chk("rst_x", d, x[d], idle_of(d));
      chk("rst_x_valid", d, x_valid[d], 1'b0);
      chk("rst_busy", d, busy[d], 1'b0);
      chk("rst_in_ready", d, in_ready[d], 1'b1);
    end
    reset = 1'b1;
    repeat (2) tick();

    // Single-word vectors
    foreach (tbl[i]) begin
      clear_caps();
      send(tbl[i].d, tbl[i].data);
      wait_idle(tbl[i].d);
      chk_int("vec_len", tbl[i].d, (tbl[i].d == 0) ? cap0.size() : cap1.size(), W);
      chk_int("vec_seq", tbl[i].d, longint'(pack_cap(tbl[i].d)), longint'(tbl[i].seq));
    end

    // Back-to-back FF,00 with in_valid held: gapless 16 bits
    clear_caps();
    took[0] = 1'b0; in_data[0] = 8'hFF; in_valid[0] = 1'b1;
    wait_took(0);
    in_data[0] = 8'h00;
    wait_took(0);
    in_valid[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("b2b_ready_low", 0, in_ready[0], 1'b0);
      tick();
    end
    chk("b2b_ready_back", 0, in_ready[0], 1'b1);
    wait_idle(0);
    chk_int("b2b_len", 0, vc0.size(), 16);
    if (vc0.size() == 16) chk_int("b2b_contig", 0, vc0[15] - vc0[0], 15);
    chk_int("b2b_bits", 0, longint'(pack_cap(0)), longint'(16'hFF00));

    // GAP=2, LSB-first: 0F then F0
    clear_caps();
    took[1] = 1'b0; in_data[1] = 8'h0F; in_valid[1] = 1'b1;
    wait_took(1);
    in_data[1] = 8'hF0;
    wait_took(1);
    in_valid[1] = 1'b0;
    wait_idle(1);
    chk_int("gap_len", 1, vc1.size(), 16);
    if (vc1.size() == 16) chk_int("gap_cycles", 1, vc1[8] - vc1[7] - 1, 2);
    chk_int("gap_bits", 1, longint'(pack_cap(1)), longint'(16'hF00F));

    // Reset mid-word with a buffered word
    clear_caps();
    took[0] = 1'b0; in_data[0] = 8'hC3; in_valid[0] = 1'b1;
    wait_took(0);
    in_data[0] = 8'h5A;
    wait_took(0);
    in_valid[0] = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (cap0.size() >= 3) begin ok = 1'b1; break; end
        tick();
      end
      if (!ok) timeout("three_bits", 0);
    end
    #2 reset = 1'b0;
    #1;
    chk("rstmid_x_valid", 0, x_valid[0], 1'b0);
    chk("rstmid_busy", 0, busy[0], 1'b0);
    chk("rstmid_x", 0, x[0], IDL_A);
    chk("rstmid_word_done", 0, word_done[0], 1'b0);
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk_int("rstmid_silent", 0, cap0.size(), 3);
    clear_caps();
    send(0, 8'h81);
    wait_idle(0);
    chk_int("rstmid_next", 0, longint'(pack_cap(0)), longint'(16'h0081));

    // in_data churns every cycle while in_valid is held
    clear_caps();
    took[0] = 1'b0;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data[0] = W'($urandom);
      tick();
    end
    in_valid[0] = 1'b0;
    wait_idle(0);
    chk_int("churn_len", 0, cap0.size(), W * accq0.size());
    if (cap0.size() == W * accq0.size()) begin
      foreach (accq0[j]) begin
        logic [W-1:0] got;
        got = '0;
        for (int b = 0; b < W; b++) got = {got[W-2:0], cap0[j*W + b]};
        chk_int("churn_word", 0, longint'(got), longint'(accq0[j]));
      end
    end

    // Random traffic on both configurations
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < N; d++) begin
        in_valid[d] = ($urandom_range(0, 3) != 0);
        in_data[d]  = W'($urandom);
      end
      tick();
    end
    for (int d = 0; d < N; d++) in_valid[d] = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
